// File: rtl/aes_pkg.sv
// Shared AES arithmetic: GF(2^8) helpers, S-box / inverse S-box, Rcon and FSM encoding.
// Used by both the encrypt datapath and the iterative decryptor.
package aes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_KEYEXP,
      ST_ROUND,
      ST_DONE
   } fsm_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
      logic [15:0] w;
      w = {a, a} << n;
      return w[15:8];
   endfunction

   // Multiplicative inverse as a^254 (square-and-multiply over exponents 2..128); maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] s;
      r = 8'h01;
      s = a;
      for (int i = 1; i < 8; i++) begin
         s = gmul(s, s);
         r = gmul(r, s);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] i;
      i = gf_inv(a);
      return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/aes_decrypt_iter_if.sv
// Job-in / result-out handshake bundle of the iterative AES decryptor.
interface aes_decrypt_iter_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] dataIn;
   logic [127:0] keyIn;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] dataOut;

   modport master (
      output in_valid, dataIn, keyIn, out_ready,
      input  in_ready, out_valid, dataOut
   );

   modport slave (
      input  in_valid, dataIn, keyIn, out_ready,
      output in_ready, out_valid, dataOut
   );
endinterface

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] rk,
   input  logic         last,
   output logic [127:0] state_out
);

   logic [127:0] t;
   logic [127:0] mixed;

   function automatic logic [7:0] mix_coef(input int k);
      case (k)
         0:       return 8'h0e;
         1:       return 8'h0b;
         2:       return 8'h0d;
         default: return 8'h09;
      endcase
   endfunction

   // Byte (r,c) sits at index 4c+r; row r rotates right by r, so it reads column (c-r) mod 4.
   always_comb begin
      // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
      t = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            t[127-8*(4*c+r) -: 8] = inv_sbox(state_in[127-8*(4*((c-r+4)%4)+r) -: 8])
                                    ^ rk[127-8*(4*c+r) -: 8];
         end
      end
   end

   always_comb begin
      mixed = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
               mixed[127-8*(4*c+r) -: 8] = mixed[127-8*(4*c+r) -: 8]
                                           ^ gmul(t[127-8*(4*c+j) -: 8], mix_coef((j-r+4)%4));
            end
         end
      end
   end

   assign state_out = last ? t : mixed;

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, reverse key schedule on the fly,
// and a one-entry cache of the round-10 key so a repeated key skips forward expansion.
module aes_decrypt_iter
   import aes_pkg::*;
#(
   parameter int Nk        = 4,
   parameter int Nr        = 10,
   parameter int KEY_CACHE = 1
) (
   input logic               clk,
   input logic               rst_n,
   aes_decrypt_iter_if.slave bus
);

   if (Nk != 4 || Nr != 10) begin : g_param_check
      $error("aes_decrypt_iter supports only AES-128 (Nk=4, Nr=10)");
   end

   fsm_e         fsm_q, fsm_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [127:0] state_q, state_d;
   logic [127:0] wk_q, wk_d;
   logic         out_valid_q, out_valid_d;
   logic [127:0] data_out_q, data_out_d;
   logic         cache_v_q, cache_v_d;
   logic [127:0] cache_key_q, cache_key_d;
   logic [127:0] cache_rk10_q, cache_rk10_d;

   logic [127:0] rk_fwd;
   logic [127:0] rk_rnd;
   logic [127:0] round_out;
   logic         cache_hit;

   function automatic logic [31:0] key_g(input logic [31:0] w, input logic [7:0] rc);
      return sub_word({w[23:0], w[31:24]}) ^ {rc, 24'h0};
   endfunction

   function automatic logic [127:0] key_step_fwd(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n0 = k[127:96] ^ key_g(k[31:0], rc);
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Undo one expansion step: the older words fall out of XORs of neighbouring newer ones.
   function automatic logic [127:0] key_step_rev(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] p0, p1, p2, p3;
      p3 = k[31:0] ^ k[63:32];
      p2 = k[63:32] ^ k[95:64];
      p1 = k[95:64] ^ k[127:96];
      p0 = k[127:96] ^ key_g(p3, rc);
      return {p0, p1, p2, p3};
   endfunction

   assign rk_fwd    = key_step_fwd(wk_q, rcon(cnt_q));
   assign rk_rnd    = key_step_rev(wk_q, rcon(cnt_q + 4'd1));
   assign cache_hit = (KEY_CACHE != 0) && cache_v_q && (bus.keyIn == cache_key_q);

   aes_inv_round u_round (
      .state_in  (state_q),
      .rk        (rk_rnd),
      .last      (cnt_q == 4'd0),
      .state_out (round_out)
   );

   always_comb begin
      fsm_d        = fsm_q;
      cnt_d        = cnt_q;
      state_d      = state_q;
      wk_d         = wk_q;
      out_valid_d  = out_valid_q;
      data_out_d   = data_out_q;
      cache_v_d    = cache_v_q;
      cache_key_d  = cache_key_q;
      cache_rk10_d = cache_rk10_q;
      case (fsm_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               if (cache_hit) begin
                  state_d = bus.dataIn ^ cache_rk10_q;
                  wk_d    = cache_rk10_q;
                  cnt_d   = 4'd9;
                  fsm_d   = ST_ROUND;
               end else begin
                  state_d     = bus.dataIn;
                  wk_d        = bus.keyIn;
                  cache_key_d = bus.keyIn;
                  cache_v_d   = 1'b0;
                  cnt_d       = 4'd1;
                  fsm_d       = ST_KEYEXP;
               end
            end
         end
         ST_KEYEXP: begin
            wk_d  = rk_fwd;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd10) begin
               cache_rk10_d = rk_fwd;
               cache_v_d    = 1'b1;
               state_d      = state_q ^ rk_fwd;
               cnt_d        = 4'd9;
               fsm_d        = ST_ROUND;
            end
         end
         ST_ROUND: begin
            wk_d    = rk_rnd;
            state_d = round_out;
            if (cnt_q == 4'd0) begin
               data_out_d  = round_out;
               out_valid_d = 1'b1;
               fsm_d       = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               fsm_d       = ST_IDLE;
            end
         end
         default: fsm_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q        <= ST_IDLE;
         cnt_q        <= 4'd0;
         state_q      <= '0;
         wk_q         <= '0;
         out_valid_q  <= 1'b0;
         data_out_q   <= '0;
         cache_v_q    <= 1'b0;
         cache_key_q  <= '0;
         cache_rk10_q <= '0;
      end else begin
         fsm_q        <= fsm_d;
         cnt_q        <= cnt_d;
         state_q      <= state_d;
         wk_q         <= wk_d;
         out_valid_q  <= out_valid_d;
         data_out_q   <= data_out_d;
         cache_v_q    <= cache_v_d;
         cache_key_q  <= cache_key_d;
         cache_rk10_q <= cache_rk10_d;
      end
   end

   assign bus.in_ready  = (fsm_q == ST_IDLE) && rst_n;
   assign bus.out_valid = out_valid_q;
   assign bus.dataOut   = data_out_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: known-answer vectors, latency, cache, backpressure, reset.
module tb_aes_decrypt_iter;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   aes_decrypt_iter_if bus0 ();
   aes_decrypt_iter_if bus1 ();

   aes_decrypt_iter #(.KEY_CACHE(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   aes_decrypt_iter #(.KEY_CACHE(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
      int           lat;
   } vec_t;

   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;

   int           n_checks = 0;
   int           n_errors = 0;
   logic [127:0] sb_q[$];
   vec_t         vecs[5];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] junk();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic run_job(input virtual aes_decrypt_iter_if vif, input logic [127:0] key,
                          input logic [127:0] ct, input logic [127:0] pt, input int exp_lat,
                          input int hold, input string name);
      int           b;
      int           lat;
      logic [127:0] first;
      logic [127:0] exp;
      b = 0;
      while (vif.in_ready !== 1'b1 && b < 50) begin
         @(posedge clk); #1; b++;
      end
      check({name, " in_ready before accept"}, 128'(vif.in_ready), 128'd1);
      vif.keyIn    = key;
      vif.dataIn   = ct;
      vif.in_valid = 1'b1;
      sb_q.push_back(pt);
      @(posedge clk); #1;
      vif.in_valid = 1'b0;
      vif.keyIn    = junk();
      vif.dataIn   = junk();
      check({name, " in_ready busy"}, 128'(vif.in_ready), 128'd0);
      lat = 0;
      while (vif.out_valid !== 1'b1 && lat < 64) begin
         @(posedge clk); #1; lat++;
      end
      check({name, " latency"}, 128'(lat), 128'(exp_lat));
      first = vif.dataOut;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({name, " held out_valid"}, 128'(vif.out_valid), 128'd1);
         check({name, " held dataOut"}, vif.dataOut, first);
         check({name, " held in_ready"}, 128'(vif.in_ready), 128'd0);
      end
      if (sb_q.size() == 0) begin
         check({name, " scoreboard empty"}, 128'd0, 128'd1);
         exp = '0;
      end else begin
         exp = sb_q.pop_front();
      end
      check({name, " dataOut"}, vif.dataOut, exp);
      // in_valid raised in DONE alongside out_ready must not start a job.
      vif.out_ready = 1'b1;
      vif.in_valid  = 1'b1;
      vif.keyIn     = junk();
      vif.dataIn    = junk();
      @(posedge clk); #1;
      vif.out_ready = 1'b0;
      vif.in_valid  = 1'b0;
      check({name, " out_valid after handshake"}, 128'(vif.out_valid), 128'd0);
      check({name, " in_ready after handshake"}, 128'(vif.in_ready), 128'd1);
      check({name, " dataOut retained"}, vif.dataOut, exp);
   endtask

   initial begin
      vecs[0] = '{KEY_B, 128'h3925841d02dc09fbdc118597196a0b32,
                  128'h3243f6a8885a308d313198a2e0370734, 20};
      vecs[1] = '{KEY_C1, CT_C1, PT_C1, 20};
      vecs[2] = '{KEY_C1, CT_C1, PT_C1, 10};
      vecs[3] = '{KEY_B, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                  128'h6bc1bee22e409f96e93d7e117393172a, 20};
      vecs[4] = '{KEY_B, 128'hf5d3d58503b9699de785895a96fdbaaf,
                  128'hae2d8a571e03ac9c9eb76fac45af8e51, 10};

      bus0.in_valid = 1'b0; bus0.out_ready = 1'b0; bus0.dataIn = '0; bus0.keyIn = '0;
      bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.dataIn = '0; bus1.keyIn = '0;
      rst_n = 1'b0;
      #2;
      check("reset in_ready", 128'(bus0.in_ready), 128'd0);
      check("reset out_valid", 128'(bus0.out_valid), 128'd0);
      check("reset dataOut", bus0.dataOut, 128'd0);
      check("reset nocache in_ready", 128'(bus1.in_ready), 128'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post-reset in_ready", 128'(bus0.in_ready), 128'd1);

      for (int i = 0; i < 5; i++) begin
         run_job(bus0, vecs[i].key, vecs[i].ct, vecs[i].pt, vecs[i].lat, 0,
                 $sformatf("vec%0d", i));
      end
      check("cache_rk10 for key B", dut0.cache_rk10_q, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      run_job(bus0, KEY_C1, CT_C1, PT_C1, 20, 7, "backpressure");

      // Cache-hit job aborted by reset part-way through the rounds.
      bus0.keyIn    = KEY_C1;
      bus0.dataIn   = CT_C1;
      bus0.in_valid = 1'b1;
      sb_q.push_back(PT_C1);
      @(posedge clk); #1;
      bus0.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("abort at rnd 4", 128'(dut0.cnt_q), 128'd4);
      check("abort out_valid before reset", 128'(bus0.out_valid), 128'd0);
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      check("abort out_valid", 128'(bus0.out_valid), 128'd0);
      check("abort dataOut", bus0.dataOut, 128'd0);
      check("abort in_ready", 128'(bus0.in_ready), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_job(bus0, KEY_C1, CT_C1, PT_C1, 20, 0, "after reset");

      run_job(bus1, KEY_C1, CT_C1, PT_C1, 20, 0, "nocache first");
      run_job(bus1, KEY_C1, CT_C1, PT_C1, 20, 0, "nocache repeat");

      check("scoreboard drained", 128'(sb_q.size()), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
